// File: rtl/led_pkg.sv
// ============================================================================
// Module      : led_pkg
// Description : Shared types and constants for the WS2812B strip driver:
//               FSM state encoding, colour/pixel widths, channel indices and
//               the per-channel enable/brightness helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam int COLOR_W = 8;
    localparam int PIXEL_W = 24;

    // Channel positions inside a {G,R,B} pixel word and in channel_en
    localparam int CH_G = 2;
    localparam int CH_R = 1;
    localparam int CH_B = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_LATCH = 3'd4
    } led_state_t;

    // A disabled channel sends zero; an enabled one is shifted right on its own,
    // so nothing carries across colour boundaries.
    function automatic logic [COLOR_W-1:0] scale_color(
        input logic [COLOR_W-1:0] color,
        input logic               enable,
        input logic [2:0]         shift
    );
        return enable ? (color >> shift) : '0;
    endfunction

endpackage : led_pkg

`default_nettype wire

// File: rtl/ws_bit_encoder.sv
// ============================================================================
// Module      : ws_bit_encoder
// Description : Generates one WS2812B bit waveform at a time. Owns the
//               in-bit timing counter and the high-time compare; ws_out is
//               registered, so the waveform trails the counter by one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws_bit_encoder #(
    parameter int CLK_PER_BIT = 15,
    parameter int T0H_CYCLES  = 4,
    parameter int T1H_CYCLES  = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_start,   // clears the timing counter ahead of a new pixel
    input  logic bit_active,  // high while bits are being transmitted
    input  logic bit_in,      // value of the bit currently on the wire
    output logic ws_out,
    output logic bit_end      // last cycle of the current bit
);

    localparam int c_CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_T0H      = c_CNT_W'(T0H_CYCLES);
    localparam logic [c_CNT_W-1:0] c_T1H      = c_CNT_W'(T1H_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_high_len;

    assign w_high_len = bit_in ? c_T1H : c_T0H;
    assign bit_end    = bit_active && (r_cnt == c_LAST_CNT);

    // Count cycles within a bit and drive the line high for the bit's high time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            ws_out <= 1'b0;
        end else begin
            if (bit_start) begin
                r_cnt <= '0;
            end else if (bit_active) begin
                r_cnt <= (r_cnt == c_LAST_CNT) ? '0 : r_cnt + 1'b1;
            end
            ws_out <= bit_active && (r_cnt < w_high_len);
        end
    end

endmodule : ws_bit_encoder

`default_nettype wire

// File: rtl/led_strip_driver.sv
// ============================================================================
// Module      : led_strip_driver
// Description : Streams NUM_PIXELS 24-bit {G,R,B} pixels from an external
//               pixel memory onto a WS2812B serial line, followed by a
//               latch (reset) low period and a frame_done pulse.
//               Optional feature macro: LED_BRIGHTNESS_EN - when defined,
//               each enabled channel is right-shifted by `brightness`;
//               otherwise the brightness input is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_strip_driver
    import led_pkg::*;
#(
    parameter int NUM_PIXELS   = 64,
    parameter int CLK_PER_BIT  = 15,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 9,
    parameter int LATCH_CYCLES = 960
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [2:0]                                            channel_en,
    input  logic [2:0]                                            brightness,
    output logic [$clog2(NUM_PIXELS > 1 ? NUM_PIXELS : 2)-1:0]    pixel_addr,
    input  logic [23:0]                                           pixel_data,
    output logic                                                  busy,
    output logic                                                  frame_done,
    output logic                                                  ws_out
);

    localparam int c_ADDR_W  = $clog2(NUM_PIXELS > 1 ? NUM_PIXELS : 2);
    localparam int c_LATCH_W = (LATCH_CYCLES > 0) ? $clog2(LATCH_CYCLES + 1) : 1;
    localparam logic [c_ADDR_W-1:0]  c_LAST_IDX   = c_ADDR_W'(NUM_PIXELS - 1);
    localparam logic [c_LATCH_W-1:0] c_LATCH_LAST = c_LATCH_W'(LATCH_CYCLES);
    localparam logic [4:0]           c_LAST_BIT   = 5'(PIXEL_W - 1);

    led_state_t           r_state;
    logic [c_ADDR_W-1:0]  r_index;
    logic [4:0]           r_bit_cnt;
    logic [PIXEL_W-1:0]   r_shift;
    logic [c_LATCH_W-1:0] r_latch_cnt;

    logic                 w_bit_end;
    logic [2:0]           w_shift_amt;
    logic [PIXEL_W-1:0]   w_pixel_scaled;

`ifdef LED_BRIGHTNESS_EN
    assign w_shift_amt = brightness;
`else
    // Brightness is accepted on the port but has no effect in this build
    logic w_unused_brightness;
    assign w_unused_brightness = ^brightness;
    assign w_shift_amt = 3'd0;
`endif

    assign w_pixel_scaled = {
        scale_color(pixel_data[CH_G*COLOR_W +: COLOR_W], channel_en[CH_G], w_shift_amt),
        scale_color(pixel_data[CH_R*COLOR_W +: COLOR_W], channel_en[CH_R], w_shift_amt),
        scale_color(pixel_data[CH_B*COLOR_W +: COLOR_W], channel_en[CH_B], w_shift_amt)
    };

    assign pixel_addr = r_index;
    assign busy       = (r_state != ST_IDLE);

    // Frame sequencer: fetch/load/send per pixel, then latch and signal completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_latch_cnt <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_index <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                // Address is already on pixel_addr; memory data arrives next cycle
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift   <= w_pixel_scaled;
                    r_bit_cnt <= '0;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_bit_end) begin
                        r_shift   <= {r_shift[PIXEL_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            if (r_index == c_LAST_IDX) begin
                                r_latch_cnt <= '0;
                                r_state     <= ST_LATCH;
                            end else begin
                                r_index <= r_index + 1'b1;
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                end
                // The first LATCH cycle still shows the last bit's trailing low
                // (ws_out is registered), so count one extra before frame_done.
                // frame_done is raised while still busy, so a start in that
                // cycle is ignored.
                ST_LATCH: begin
                    if (frame_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_latch_cnt == c_LATCH_LAST) begin
                        frame_done <= 1'b1;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ws_bit_encoder #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .T0H_CYCLES  (T0H_CYCLES),
        .T1H_CYCLES  (T1H_CYCLES)
    ) u_bit_encoder (
        .clk        (clk),
        .rst        (rst),
        .bit_start  (r_state == ST_LOAD),
        .bit_active (r_state == ST_SEND),
        .bit_in     (r_shift[PIXEL_W-1]),
        .ws_out     (ws_out),
        .bit_end    (w_bit_end)
    );

endmodule : led_strip_driver

`default_nettype wire
